ram_fifo_ctrl: RTL and testbench

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

---
 rtl/ram_fifo_ctrl.sv | 105 ++++++++++
 tb/tb_ram_fifo_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving an external synchronous-read RAM, with a registered output word.
// The read side prefetches into out_data so downstream sees a registered valid/data pair.
module ram_fifo_ctrl #(
    parameter int data_width = 8,
    parameter int addr_width = 4,
    parameter int depth      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [data_width-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [data_width-1:0] out_data,
    input  logic                  out_ready,
    output logic [addr_width:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  ram_wr_en,
    output logic                  ram_port_en_0,
    output logic [addr_width-1:0] ram_addr_0,
    output logic [data_width-1:0] ram_data_in,
    output logic                  ram_port_en_1,
    output logic [addr_width-1:0] ram_addr_1,
    input  logic [data_width-1:0] ram_data_out_1
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } rd_state_t;

    localparam logic [addr_width:0] ptr_one   = 1;
    localparam logic [addr_width:0] depth_cnt = depth[addr_width:0];

    rd_state_t             state, state_next;
    logic [addr_width:0]   wr_ptr, rd_ptr, unfetched;
    logic                  wr_acc, pop, rd_issue;

    assign full      = (count == depth_cnt);
    assign empty     = (count == '0);
    assign in_ready  = !full && !rst;
    assign wr_acc    = in_valid && in_ready;
    assign out_valid = (state == HOLD);
    assign pop       = out_valid && out_ready;
    assign unfetched = wr_ptr - rd_ptr;

    assign ram_wr_en     = wr_acc;
    assign ram_port_en_0 = wr_acc;
    assign ram_addr_0    = wr_ptr[addr_width-1:0];
    assign ram_data_in   = in_data;
    assign ram_port_en_1 = rd_issue;
    assign ram_addr_1    = rd_ptr[addr_width-1:0];

    always_comb begin
        state_next = state;
        rd_issue   = 1'b0;
        case (state)
            EMPTY: begin
                if (unfetched != '0) begin
                    rd_issue   = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: state_next = HOLD;
            HOLD: begin
                if (out_ready) begin
                    if (unfetched != '0) begin
                        rd_issue   = 1'b1;
                        state_next = FETCH;
                    end else begin
                        state_next = EMPTY;
                    end
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            out_data <= '0;
        end else begin
            state <= state_next;
            if (wr_acc)
                wr_ptr <= wr_ptr + ptr_one;
            if (rd_issue)
                rd_ptr <= rd_ptr + ptr_one;
            // RAM read data arrives the cycle after issue, which is always FETCH
            if (state == FETCH)
                out_data <= ram_data_out_1;
            case ({wr_acc, pop})
                2'b10:   count <= count + ptr_one;
                2'b01:   count <= count - ptr_one;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl: cycle table for latency/simultaneous cases,
// plus sequences for reset, fill/drain and pointer wrap, with a behavioural RAM.
module tb_ram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [4:0] count;
    logic       full, empty;
    logic       ram_wr_en, ram_port_en_0, ram_port_en_1;
    logic [3:0] ram_addr_0, ram_addr_1;
    logic [7:0] ram_data_in;
    logic [7:0] ram_data_out_1;

    int n_cmp = 0;
    int n_bad = 0;

    ram_fifo_ctrl #(.data_width(8), .addr_width(4), .depth(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .count(count), .full(full), .empty(empty),
        .ram_wr_en(ram_wr_en), .ram_port_en_0(ram_port_en_0),
        .ram_addr_0(ram_addr_0), .ram_data_in(ram_data_in),
        .ram_port_en_1(ram_port_en_1), .ram_addr_1(ram_addr_1),
        .ram_data_out_1(ram_data_out_1)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_addr_0] <= ram_data_in;
        if (ram_port_en_1) ram_data_out_1 <= mem[ram_addr_1];
    end

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       ewr;
        logic [3:0] eaddr;
        logic       erd;
        logic       eov;
        logic       chk_d;
        logic [7:0] ed;
        logic [4:0] ecnt;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // inputs change on the falling edge; outputs are sampled 1 time unit later
    task automatic drive(input logic iv, input logic [7:0] d, input logic ordy);
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
    endtask

    task automatic write_word(input logic [7:0] d, input logic [3:0] addr);
        drive(1'b1, d, 1'b0);
        chk("wr_en", 32'(ram_wr_en), 32'd1);
        chk("wr_port_en", 32'(ram_port_en_0), 32'd1);
        chk("wr_addr", 32'(ram_addr_0), 32'(addr));
        chk("wr_data", 32'(ram_data_in), 32'(d));
    endtask

    task automatic drain(input logic [7:0] first, input int n);
        int k = 0;
        for (int c = 0; c < 4 * n + 10 && k < n; c++) begin
            drive(1'b0, 8'h00, 1'b1);
            if (out_valid) begin
                chk("drain_data", 32'(out_data), 32'(8'(first + 8'(k))));
                k++;
            end
        end
        chk("drain_done", 32'(k), 32'(n));
        drive(1'b0, 8'h00, 1'b0);
        chk("drain_count", 32'(count), 32'd0);
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_ov", 32'(out_valid), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_ov_now", 32'(out_valid), 32'd0);
        chk("rst_count_now", 32'(count), 32'd0);
        repeat (2) @(posedge clk);
        drive(1'b1, 8'h5A, 1'b1);
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_wr_en", 32'(ram_wr_en), 32'd0);
        chk("rst_rd_en", 32'(ram_port_en_1), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        //           iv   d      or   wr   addr  rd   ov   chkd  ed     cnt
        tbl[0]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0};
        tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 8'h00, 5'd1};
        tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 8'hA5, 5'd1};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 8'hA5, 5'd1};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0};
        tbl[6]  = '{1'b1, 8'h11, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0};
        tbl[7]  = '{1'b1, 8'h12, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 8'h00, 5'd1};
        tbl[8]  = '{1'b1, 8'h13, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 8'h00, 5'd2};
        tbl[9]  = '{1'b1, 8'h14, 1'b0, 1'b1, 4'd4, 1'b0, 1'b1, 1'b1, 8'h11, 5'd3};
        tbl[10] = '{1'b1, 8'h15, 1'b0, 1'b1, 4'd5, 1'b0, 1'b1, 1'b1, 8'h11, 5'd4};
        tbl[11] = '{1'b1, 8'h16, 1'b1, 1'b1, 4'd6, 1'b1, 1'b1, 1'b1, 8'h11, 5'd5};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd5};
        tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 8'h12, 5'd5};
        tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd4};
        tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 8'h13, 5'd4};

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'h00;
        out_ready = 1'b0;
        do_reset();

        // table starts in the first cycle after reset release
        for (int i = 0; i < 16; i++) begin
            if (i > 0) drive(tbl[i].iv, tbl[i].d, tbl[i].ordy);
            else begin
                in_valid  = tbl[0].iv;
                in_data   = tbl[0].d;
                out_ready = tbl[0].ordy;
                #1;
            end
            chk($sformatf("v%0d_wr_en", i), 32'(ram_wr_en), 32'(tbl[i].ewr));
            chk($sformatf("v%0d_port_en_0", i), 32'(ram_port_en_0), 32'(tbl[i].ewr));
            if (tbl[i].ewr)
                chk($sformatf("v%0d_addr_0", i), 32'(ram_addr_0), 32'(tbl[i].eaddr));
            chk($sformatf("v%0d_rd_en", i), 32'(ram_port_en_1), 32'(tbl[i].erd));
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].eov));
            if (tbl[i].chk_d)
                chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(tbl[i].ed));
            chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].ecnt));
        end

        // fifth held word, then reset mid-operation
        write_word(8'h17, 4'd7);
        drive(1'b0, 8'h00, 1'b0);
        chk("pre_rst_count", 32'(count), 32'd5);
        do_reset();

        // fill to capacity with the consumer stalled
        for (int i = 0; i < 16; i++) write_word(8'(i + 1), 4'(i));
        drive(1'b1, 8'hEE, 1'b0);
        chk("full_count", 32'(count), 32'd16);
        chk("full_flag", 32'(full), 32'd1);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_wr_en", 32'(ram_wr_en), 32'd0);
        chk("full_port_en_0", 32'(ram_port_en_0), 32'd0);
        drive(1'b0, 8'h00, 1'b0);
        chk("full_count_held", 32'(count), 32'd16);
        chk("full_head", 32'(out_data), 32'd1);
        drain(8'd1, 16);

        // wrap: pointers start at 0, advance by 10, then cross depth-1 -> 0
        do_reset();
        for (int i = 0; i < 10; i++) write_word(8'(8'd100 + 8'(i)), 4'(i));
        drain(8'd100, 10);
        for (int i = 0; i < 12; i++) write_word(8'(8'd200 + 8'(i)), 4'((10 + i) % 16));
        drive(1'b0, 8'h00, 1'b0);
        chk("wrap_count", 32'(count), 32'd12);
        drain(8'd200, 12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
